fifo_reg_unit: RTL and testbench
================================

Name: fifo_reg_unit

Overview:
- Parametrised successor to the fabric's single-stage 32-bit register primitive.
- Provides an elastic register buffer of configurable width and depth, with a valid/ready handshake on both sides.
- Lets the fabric router absorb back-pressure between ALU and IO tiles without losing data.
- Keeps the tie-off parameters `tide_en` and `tide_rst` so the tools can hard-wire enable and reset as they do for the single-stage register.

Parameters:
- WIDTH, 32: data width in bits; must be ≥1.
- DEPTH, 4: number of entries; power of two, ≥2.
- RST_VALUE, 0: value driven on reg_out while the buffer is empty.
- tide_en, 0: 1 ties the internal enable high; the en port is ignored.
- tide_rst, 0: 1 ties the internal reset inactive; the rst port is ignored.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-low reset.
- en, input, 1: global enable; 0 freezes all state.
- reg_in, input, WIDTH: write data.
- in_valid, input, 1: producer has data on reg_in.
- in_ready, output, 1: buffer accepts data this cycle.
- reg_out, output, WIDTH: head-of-buffer data.
- out_valid, output, 1: reg_out holds valid data.
- out_ready, input, 1: consumer takes data this cycle.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

Behaviour:
- Internal signals:
  - en_eff = tide_en ? 1 : en
  - rst_eff = tide_rst ? 1 : rst (active-low)
- Reset (rst_eff=0, asynchronous, any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=0 while reset is asserted, reg_out=RST_VALUE.
  - Storage contents are don't-care.
  - Deassertion takes effect at the next clk edge: in_ready=1 the same cycle reset is released, provided en_eff=1.
- Handshake:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = en_eff & (count != DEPTH)
  - out_valid = en_eff & (count != 0)
- Push: mem[wr_ptr] <= reg_in; wr_ptr wraps modulo DEPTH.
- Pop: rd_ptr increments, wrapping modulo DEPTH.
- count update: +1 on push-only, −1 on pop-only, unchanged on push+pop or idle.
- First-word-fall-through:
  - reg_out = mem[rd_ptr] when count != 0, else RST_VALUE.
  - Latency from push to out_valid is 1 cycle.
- Full (count=DEPTH): in_ready=0 even if out_ready=1 in the same cycle; a push is accepted the cycle after the pop frees a slot.
- Empty (count=0): no pop is possible; reg_out=RST_VALUE.
- Simultaneous push and pop at 0<count<DEPTH: both occur; count is held; ordering is strict FIFO.
- en_eff=0:
  - in_ready=0 and out_valid=0, so no push or pop occurs.
  - Pointers, count and storage hold their values.
  - reg_out still shows the head value.
  - On re-enable, operation resumes with contents intact.
- in_valid without in_ready: the producer holds its data (standard handshake); the block does not latch it.
- Pointers are $clog2(DEPTH) bits wide; wrap is natural overflow.

Optional Feature:
- Macro: FIFO_REG_UNIT_BYPASS_EN.
- Defined: zero-latency bypass when empty.
  - If count=0 and en_eff=1, then out_valid=in_valid and reg_out=reg_in, combinationally.
  - If out_ready=1 in that cycle, the word passes through without being written and count stays 0.
  - If out_ready=0, the word is written normally and count becomes 1.
  - in_ready is unchanged.
- Undefined: no combinational in→out path; the minimum latency is 1 cycle as described above.

Test Plan:
- Reset: hold rst=0 with in_valid=1, reg_in=0xDEADBEEF, RST_VALUE=0x0 → out_valid=0, count=0, reg_out=0x0. Release rst → in_ready=1 that cycle; first push shows out_valid=1 and reg_out=0xDEADBEEF next cycle.
- Fill and overflow (DEPTH=4, out_ready=0): push 0x1,0x2,0x3,0x4,0x5 → count=4 and in_ready=0 after the 4th push; 0x5 is not accepted. Then out_ready=1 → reads 0x1,0x2,0x3,0x4 in order, then 0x5 once re-pushed.
- Streaming (in_valid=1, out_ready=1 continuously after 1 fill) with values 0x10..0x1F → count stays 1; output sequence equals input sequence delayed by 1 cycle; pointers wrap 4 times with no loss.
- Freeze: count=2, drive en=0 for 3 cycles with in_valid=1 and out_ready=1 → in_ready=0, out_valid=0, count stays 2. Set en=1 → head value is unchanged and is popped first.
- Async reset mid-operation: count=3, pulse rst low between clock edges → count=0, out_valid=0 immediately, without waiting for a clk edge. Previous data never appears on the output.
- Tie-offs: tide_en=1 with en=0 → normal flow. tide_rst=1 with rst pulsed → count is unaffected. Bypass build (FIFO_REG_UNIT_BYPASS_EN), empty, in_valid=1, out_ready=1, reg_in=0xA5 → reg_out=0xA5 and out_valid=1 in the same cycle, count stays 0.

Source files
------------

// File: rtl/fifo_reg_unit.sv
// Elastic register buffer: DEPTH-entry first-word-fall-through FIFO with valid/ready on both sides.
// Optional zero-latency empty bypass is enabled by defining FIFO_REG_UNIT_BYPASS_EN.
module fifo_reg_unit #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RST_VALUE = '0,
  parameter bit               tide_en   = 1'b0,
  parameter bit               tide_rst  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         reg_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         reg_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             en_eff;
  logic             rst_eff;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             through;
  logic             wr_en;
  logic             rd_en;

  assign en_eff  = tide_en  ? 1'b1 : en;
  assign rst_eff = tide_rst ? 1'b1 : rst;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // Gated by reset so the producer sees no acceptance while reset is held.
  assign in_ready = rst_eff & en_eff & ~full;

`ifdef FIFO_REG_UNIT_BYPASS_EN
  assign out_valid = rst_eff & en_eff & (empty ? in_valid : 1'b1);
  assign reg_out   = !empty ? mem[rd_ptr] :
                     (rst_eff & en_eff) ? reg_in : RST_VALUE;
  // A word arriving at an empty buffer that the consumer takes at once is never stored.
  assign through   = empty & push & out_ready;
`else
  assign out_valid = rst_eff & en_eff & ~empty;
  assign reg_out   = empty ? RST_VALUE : mem[rd_ptr];
  assign through   = 1'b0;
`endif

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign wr_en = push & ~through;
  assign rd_en = pop & ~through;

  always_ff @(posedge clk or negedge rst_eff) begin
    if (!rst_eff) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en_eff) begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; its contents are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= reg_in;
  end

endmodule

// File: tb/tb_fifo_reg_unit.sv
// Directed bench for fifo_reg_unit: default instance plus tide_en and tide_rst tie-off instances.
module tb_fifo_reg_unit;

  logic        clk;
  logic        rst, en, in_valid, out_ready;
  logic [31:0] reg_in;
  logic        in_ready, out_valid;
  logic [31:0] reg_out;
  logic [2:0]  count;

  logic        te_en, te_in_valid, te_out_ready, te_in_ready, te_out_valid;
  logic [31:0] te_in, te_out;
  logic [2:0]  te_count;

  logic        tr_rst, tr_in_valid, tr_out_ready, tr_in_ready, tr_out_valid;
  logic [31:0] tr_in, tr_out;
  logic [2:0]  tr_count;
  logic        tr_en;

  int checks = 0;
  int errors = 0;

  fifo_reg_unit #(.WIDTH(32), .DEPTH(4), .RST_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .reg_in(reg_in), .in_valid(in_valid),
    .in_ready(in_ready), .reg_out(reg_out), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  fifo_reg_unit #(.WIDTH(32), .DEPTH(4), .RST_VALUE(32'h0), .tide_en(1'b1)) dut_te (
    .clk(clk), .rst(rst), .en(te_en), .reg_in(te_in), .in_valid(te_in_valid),
    .in_ready(te_in_ready), .reg_out(te_out), .out_valid(te_out_valid),
    .out_ready(te_out_ready), .count(te_count)
  );

  fifo_reg_unit #(.WIDTH(32), .DEPTH(4), .RST_VALUE(32'h0), .tide_rst(1'b1)) dut_tr (
    .clk(clk), .rst(tr_rst), .en(tr_en), .reg_in(tr_in), .in_valid(tr_in_valid),
    .in_ready(tr_in_ready), .reg_out(tr_out), .out_valid(tr_out_valid),
    .out_ready(tr_out_ready), .count(tr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; en = 1'b1; in_valid = 1'b1; reg_in = 32'hDEADBEEF; out_ready = 1'b0;
    te_en = 1'b0; te_in_valid = 1'b0; te_out_ready = 1'b0; te_in = '0;
    tr_rst = 1'b1; tr_en = 1'b1; tr_in_valid = 1'b0; tr_out_ready = 1'b1; tr_in = '0;

    // Reset held with a producer asserting data
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_reg_out", reg_out, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1; #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; #1;
    chk("first_out_valid", {31'b0, out_valid}, 32'd1);
    chk("first_reg_out", reg_out, 32'hDEADBEEF);
    chk("first_count", {29'b0, count}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("first_drain", {29'b0, count}, 32'd0);
    chk("empty_reg_out", reg_out, 32'h0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      reg_in = i; in_valid = 1'b1; #1;
      chk($sformatf("fill_in_ready_%0d", i), {31'b0, in_ready}, (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_in_ready_with_pop", {31'b0, in_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_%0d", k), reg_out, k);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", {29'b0, count}, 32'd0);
    reg_in = 32'h5; in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("repush_5", reg_out, 32'h5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Streaming with one word resident
    reg_in = 32'h10; in_valid = 1'b1; tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      reg_in = 32'h10 + i; #1;
      chk($sformatf("stream_out_%0d", i), reg_out, 32'h10 + i - 1);
      chk($sformatf("stream_cnt_%0d", i), {29'b0, count}, 32'd1);
      tick();
    end
    in_valid = 1'b0; #1;
    chk("stream_last", reg_out, 32'h1F);
    tick(); out_ready = 1'b0;
    chk("stream_empty", {29'b0, count}, 32'd0);

    // Freeze with en low
    in_valid = 1'b1; reg_in = 32'h21; tick(); reg_in = 32'h22; tick();
    en = 1'b0; reg_in = 32'h99; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("frz_in_ready", {31'b0, in_ready}, 32'd0);
      chk("frz_out_valid", {31'b0, out_valid}, 32'd0);
      chk("frz_count", {29'b0, count}, 32'd2);
      chk("frz_reg_out", reg_out, 32'h21);
      tick();
    end
    en = 1'b1; in_valid = 1'b0; #1;
    chk("resume_head", reg_out, 32'h21);
    chk("resume_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("resume_second", reg_out, 32'h22);
    tick(); out_ready = 1'b0;
    chk("resume_empty", {29'b0, count}, 32'd0);

    // Asynchronous reset between edges
    in_valid = 1'b1;
    reg_in = 32'h31; tick(); reg_in = 32'h32; tick(); reg_in = 32'h33; tick();
    in_valid = 1'b0;
    chk("pre_arst_count", {29'b0, count}, 32'd3);
    #2 rst = 1'b0; #1;
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_reg_out", reg_out, 32'h0);
    #1 rst = 1'b1;
    tick();
    chk("post_arst_valid", {31'b0, out_valid}, 32'd0);
    reg_in = 32'h40; in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("post_arst_head", reg_out, 32'h40);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifdef FIFO_REG_UNIT_BYPASS_EN
    reg_in = 32'hA5; in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("byp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("byp_reg_out", reg_out, 32'hA5);
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    chk("byp_count", {29'b0, count}, 32'd0);
`else
    reg_in = 32'hA5; in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("nobyp_out_valid", {31'b0, out_valid}, 32'd0);
    chk("nobyp_reg_out", reg_out, 32'h0);
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    chk("nobyp_count", {29'b0, count}, 32'd1);
    chk("nobyp_head", reg_out, 32'hA5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

    // tide_en instance with en held low
    te_in_valid = 1'b1; te_in = 32'h55; #1;
    chk("te_in_ready", {31'b0, te_in_ready}, 32'd1);
    tick(); te_in = 32'h66; tick(); te_in_valid = 1'b0;
    chk("te_count", {29'b0, te_count}, 32'd2);
    chk("te_head", te_out, 32'h55);
    te_out_ready = 1'b1; tick();
    chk("te_second", te_out, 32'h66);
    tick(); te_out_ready = 1'b0;
    chk("te_empty", {29'b0, te_count}, 32'd0);

    // tide_rst instance: drained for the whole run above, then rst pulsed
    tr_out_ready = 1'b0;
    chk("tr_drained", {29'b0, tr_count}, 32'd0);
    tr_in_valid = 1'b1; tr_in = 32'h71; tick(); tr_in = 32'h72; tick(); tr_in_valid = 1'b0;
    tr_rst = 1'b0; tick(); tick(); #1;
    chk("tr_count", {29'b0, tr_count}, 32'd2);
    chk("tr_head", tr_out, 32'h71);
    chk("tr_valid", {31'b0, tr_out_valid}, 32'd1);
    tr_rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
